// File: rtl/imem_loader_pkg.sv
// Shared definitions for the serial instruction-memory loader: FSM states,
// the default frame start byte and the frame layout constants.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StWrite,
    StCsum,
    StDone,
    StError
  } loader_state_e;

  localparam logic [7:0] MagicDefault = 8'hA5;

  // Byte positions within a frame header; data starts right after the length.
  localparam int unsigned PosMagic     = 0;
  localparam int unsigned PosLenLo     = 1;
  localparam int unsigned PosLenHi     = 2;
  localparam int unsigned PosData      = 3;
  localparam int unsigned BytesPerWord = 4;

  function automatic logic [31:0] word_byte_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Collects data bytes little-endian into a 32-bit word, counts bytes within the
// word and keeps the running XOR checksum of every data byte in the frame.
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        last_byte,
  output logic [7:0]  csum
);

  logic [31:0] word_q;
  logic [1:0]  cnt_q;
  logic [7:0]  csum_q;

  // Shifting in from the top leaves the first byte in [7:0] after four shifts.
  assign word_next = {byte_in, word_q[31:8]};
  assign last_byte = (cnt_q == 2'(BytesPerWord - 1));
  assign csum      = csum_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_q <= '0;
      cnt_q  <= '0;
      csum_q <= '0;
    end else if (shift_en) begin
      word_q <= word_next;
      cnt_q  <= cnt_q + 2'd1;
      csum_q <= csum_q ^ byte_in;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a framed program image over a byte stream, writes it word by word
// into instruction memory and holds the core in reset until a good load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 64,
  parameter logic [7:0]  MAGIC     = MagicDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_err
);

  localparam int unsigned IdxW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  loader_state_e   state_q;
  logic [7:0]      len_lo_q;
  logic [15:0]     len_q;
  logic [IdxW-1:0] idx_q;

  logic            accept;
  logic            start;
  logic            data_byte;
  logic            last_byte;
  logic            idx_last;
  logic [15:0]     len_rx;
  logic [31:0]     word_next;
  logic [7:0]      csum;

  // Only WRITE stalls the stream, so a byte offered then simply waits a cycle.
  assign rx_ready  = (state_q != StWrite);
  assign accept    = rx_valid & rx_ready;
  assign start     = accept && (rx_data == MAGIC) &&
                     (state_q inside {StIdle, StDone, StError});
  assign data_byte = accept && (state_q == StData);
  assign len_rx    = {rx_data, len_lo_q};
  assign idx_last  = ((16'(idx_q) + 16'd1) == len_q);

  loader_word_assembler u_word_assembler (
    .clk       (clk),
    .rst       (rst),
    .clear     (start),
    .shift_en  (data_byte),
    .byte_in   (rx_data),
    .word_next (word_next),
    .last_byte (last_byte),
    .csum      (csum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_lo_q   <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            state_q   <= StLenLo;
            core_rst  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            idx_q     <= '0;
          end
        end
        StLenLo: begin
          if (accept) begin
            len_lo_q <= rx_data;
            state_q  <= StLenHi;
          end
        end
        StLenHi: begin
          if (accept) begin
            len_q <= len_rx;
            if (32'(len_rx) > MAX_WORDS) begin
              state_q  <= StError;
              load_err <= 1'b1;
            end else if (len_rx == 16'd0) begin
              state_q <= StCsum;
            end else begin
              state_q <= StData;
            end
          end
        end
        StData: begin
          if (data_byte && last_byte) begin
            state_q    <= StWrite;
            imem_we    <= 1'b1;
            imem_wdata <= word_next;
            imem_addr  <= word_byte_addr(16'(idx_q));
          end
        end
        StWrite: begin
          // Index stays on the last word so it never reaches MAX_WORDS.
          if (idx_last) begin
            state_q <= StCsum;
          end else begin
            state_q <= StData;
            idx_q   <= idx_q + IdxW'(1);
          end
        end
        StCsum: begin
          if (accept) begin
            if (rx_data == csum) begin
              state_q   <= StDone;
              core_rst  <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state_q  <= StError;
              load_err <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: frames are built from the
// documented byte format and every write and status flag is predicted here.
module tb_imem_loader;

  localparam int unsigned MW      = 64;
  localparam logic [7:0]  MAGIC_B = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        load_done;
  logic        load_err;

  int checks = 0;
  int failures = 0;
  int ready_low = 0;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [31:0] exp_words[$];
  logic [7:0]  frame_q[$];

  imem_loader #(
    .MAX_WORDS (MW),
    .MAGIC     (MAGIC_B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Write capture plus the stall rule: ready is low exactly when a write is issued.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      cap_addr.push_back(imem_addr);
      cap_data.push_back(imem_wdata);
    end
    if (rx_ready === 1'b0) ready_low++;
    if (imem_we === 1'b1 || rx_ready === 1'b0) begin
      checks++;
      if (rx_ready !== ~imem_we) begin
        failures++;
        $display("FAIL ready_vs_write rx_ready=%b imem_we=%b expected rx_ready=~imem_we",
                 rx_ready, imem_we);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout rx_ready stuck at %b, expected 1", rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int max_gap);
    for (int i = first; i <= last; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(frame_q[i]);
    end
  endtask

  // Frame = MAGIC, N (LE16), 4*N LE data bytes, XOR checksum (optionally corrupted).
  task automatic make_frame(input int n, input bit with_body, input logic [7:0] flip);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] n16;
    cs  = 8'h00;
    n16 = 16'(n);
    frame_q.delete();
    frame_q.push_back(MAGIC_B);
    frame_q.push_back(n16[7:0]);
    frame_q.push_back(n16[15:8]);
    if (with_body) begin
      for (int i = 0; i < n; i++) begin
        w = exp_words[i];
        for (int b = 0; b < 4; b++) begin
          frame_q.push_back(w[8*b +: 8]);
          cs = cs ^ w[8*b +: 8];
        end
      end
      frame_q.push_back(cs ^ flip);
    end
  endtask

  task automatic clear_capture();
    cap_addr.delete();
    cap_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1 || imem_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake rx_ready=%b imem_we=%b expected 1/0", rx_ready, imem_we);
    end
    checks++;
    if (imem_addr !== 32'h0 || imem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus addr=%h wdata=%h expected 0/0", imem_addr, imem_wdata);
    end
    checks++;
    if (core_rst !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags core_rst=%b done=%b err=%b expected 1/0/0",
               core_rst, load_done, load_err);
    end
  endtask

  task automatic test_two_words();
    exp_words = '{32'h00500093, 32'h00100113};
    clear_capture();
    make_frame(2, 1'b1, 8'h00);
    send_range(0, frame_q.size() - 1, 2);
    checks++;
    if (cap_addr.size() != 2) begin
      failures++;
      $display("FAIL two_words_count got=%0d expected 2", cap_addr.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (cap_addr[i] !== 32'(4 * i) || cap_data[i] !== exp_words[i]) begin
          failures++;
          $display("FAIL two_words_write%0d got addr=%h data=%h expected addr=%h data=%h",
                   i, cap_addr[i], cap_data[i], 32'(4 * i), exp_words[i]);
        end
      end
    end
    checks++;
    if (load_done !== 1'b1 || core_rst !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL two_words_flags done=%b core_rst=%b err=%b expected 1/0/0",
               load_done, core_rst, load_err);
    end
  endtask

  task automatic test_bad_csum();
    exp_words = '{32'h00000013};
    clear_capture();
    make_frame(1, 1'b1, 8'h01);
    send_range(0, frame_q.size() - 1, 1);
    checks++;
    if (cap_addr.size() != 1 || cap_addr[0] !== 32'h0 || cap_data[0] !== 32'h00000013) begin
      failures++;
      $display("FAIL bad_csum_write count=%0d expected one write of 00000013 at 0",
               cap_addr.size());
    end
    checks++;
    if (load_err !== 1'b1 || core_rst !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL bad_csum_flags err=%b core_rst=%b done=%b expected 1/1/0",
               load_err, core_rst, load_done);
    end
  endtask

  task automatic test_too_long();
    clear_capture();
    make_frame(MW + 1, 1'b0, 8'h00);
    send_range(0, 1, 0);
    checks++;
    if (core_rst !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL too_long_midframe core_rst=%b done=%b expected 1/0", core_rst, load_done);
    end
    send_range(2, 2, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (cap_addr.size() != 0 || load_err !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL too_long writes=%0d err=%b done=%b expected 0/1/0",
               cap_addr.size(), load_err, load_done);
    end
  endtask

  task automatic test_empty_then_restart();
    clear_capture();
    exp_words.delete();
    make_frame(0, 1'b1, 8'h00);
    send_range(0, frame_q.size() - 1, 0);
    checks++;
    if (cap_addr.size() != 0 || load_done !== 1'b1 || core_rst !== 1'b0) begin
      failures++;
      $display("FAIL empty_frame writes=%0d done=%b core_rst=%b expected 0/1/0",
               cap_addr.size(), load_done, core_rst);
    end
    exp_words = '{32'hA5A5_00A5};
    make_frame(1, 1'b1, 8'h00);
    send_range(0, 0, 0);
    checks++;
    if (core_rst !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL restart_magic core_rst=%b done=%b expected 1/0", core_rst, load_done);
    end
    send_range(1, frame_q.size() - 1, 1);
    checks++;
    if (cap_addr.size() != 1 || cap_data[0] !== 32'hA5A5_00A5 || load_done !== 1'b1) begin
      failures++;
      $display("FAIL magic_as_data writes=%0d done=%b expected one write of a5a500a5, done=1",
               cap_addr.size(), load_done);
    end
  endtask

  task automatic test_back_to_back();
    exp_words = '{32'h11223344, 32'hA5A5A5A5, 32'hDEADBEEF};
    clear_capture();
    make_frame(3, 1'b1, 8'h00);
    ready_low = 0;
    send_range(0, frame_q.size() - 1, 0);
    checks++;
    if (ready_low != 3) begin
      failures++;
      $display("FAIL b2b_stalls got=%0d expected 3", ready_low);
    end
    checks++;
    if (cap_addr.size() != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d expected 3", cap_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cap_addr[i] !== 32'(4 * i) || cap_data[i] !== exp_words[i]) begin
          failures++;
          $display("FAIL b2b_write%0d got addr=%h data=%h expected addr=%h data=%h",
                   i, cap_addr[i], cap_data[i], 32'(4 * i), exp_words[i]);
        end
      end
    end
    checks++;
    if (load_done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_done got=%b expected 1", load_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    exp_words = '{32'hCAFE0001, 32'hCAFE0002};
    clear_capture();
    make_frame(2, 1'b1, 8'h00);
    send_range(0, 4, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (cap_addr.size() != 0 || imem_we !== 1'b0 || rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_idle writes=%0d we=%b ready=%b expected 0/0/1",
               cap_addr.size(), imem_we, rx_ready);
    end
    checks++;
    if (core_rst !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_flags core_rst=%b done=%b err=%b expected 1/0/0",
               core_rst, load_done, load_err);
    end
    send_range(0, frame_q.size() - 1, 1);
    checks++;
    if (cap_addr.size() != 2 || cap_data[0] !== exp_words[0] || cap_data[1] !== exp_words[1]
        || cap_addr[1] !== 32'h4 || load_done !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_reload writes=%0d done=%b expected 2 correct writes, done=1",
               cap_addr.size(), load_done);
    end
  endtask

  task automatic test_random();
    int  n;
    bit  too_long;
    logic [7:0] flip;
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 7))
        0:       n = MW + 1 + int'($urandom_range(0, 4));
        1:       n = MW;
        default: n = int'($urandom_range(0, 8));
      endcase
      if (t == 0) n = MW;
      too_long = (n > int'(MW));
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
      clear_capture();
      make_frame(n, !too_long, flip);
      send_range(0, frame_q.size() - 1, int'($urandom_range(0, 3)));
      repeat (2) @(negedge clk);
      checks++;
      if (cap_addr.size() != (too_long ? 0 : n)) begin
        failures++;
        $display("FAIL rand%0d_count n=%0d got=%0d expected %0d",
                 t, n, cap_addr.size(), too_long ? 0 : n);
      end else begin
        for (int i = 0; i < cap_addr.size(); i++) begin
          if (cap_addr[i] !== 32'(4 * i) || cap_data[i] !== exp_words[i]) begin
            checks++;
            failures++;
            $display("FAIL rand%0d_write%0d got addr=%h data=%h expected addr=%h data=%h",
                     t, i, cap_addr[i], cap_data[i], 32'(4 * i), exp_words[i]);
          end
        end
      end
      checks++;
      if (too_long || flip != 8'h00) begin
        if (load_err !== 1'b1 || load_done !== 1'b0 || core_rst !== 1'b1) begin
          failures++;
          $display("FAIL rand%0d_err_flags err=%b done=%b core_rst=%b expected 1/0/1",
                   t, load_err, load_done, core_rst);
        end
      end else if (load_done !== 1'b1 || load_err !== 1'b0 || core_rst !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_ok_flags done=%b err=%b core_rst=%b expected 1/0/0",
                 t, load_done, load_err, core_rst);
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_bad_csum();
    test_too_long();
    test_empty_then_restart();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
